// File: rtl/bs_step_sequencer_if.sv
// -----------------------------------------------------------------------------
// bs_step_sequencer_if
// Purpose : groups the run-control handshake and the step/strobe outputs of
//           the bit-serial step sequencer into a single bundle.
// Signals :
//   start      request a run (honoured only while busy=0)
//   cfg_inner  last inner index, latched on an accepted start
//   cfg_outer  last outer index, latched on an accepted start
//   cfg_cont   continuous mode, latched on an accepted start
//   stop       clears the latched continuous flag
//   en         advance enable (0 holds all counters)
//   busy       high while a run is in progress
//   inner_idx  current inner bit-step
//   outer_idx  current outer pass
//   first      busy && inner_idx==0
//   last       busy && inner_idx==latched inner max
//   done       one-cycle pulse after the final step of a one-shot run
// Modports: master drives the controls; slave is the sequencer itself.
// -----------------------------------------------------------------------------
interface bs_step_sequencer_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4
);
    logic             start;
    logic [IN_W-1:0]  cfg_inner;
    logic [OUT_W-1:0] cfg_outer;
    logic             cfg_cont;
    logic             stop;
    logic             en;
    logic             busy;
    logic [IN_W-1:0]  inner_idx;
    logic [OUT_W-1:0] outer_idx;
    logic             first;
    logic             last;
    logic             done;

    modport master (
        output start, cfg_inner, cfg_outer, cfg_cont, stop, en,
        input  busy, inner_idx, outer_idx, first, last, done
    );

    modport slave (
        input  start, cfg_inner, cfg_outer, cfg_cont, stop, en,
        output busy, inner_idx, outer_idx, first, last, done
    );
endinterface

// File: rtl/bs_step_sequencer.sv
// -----------------------------------------------------------------------------
// bs_step_sequencer
// Purpose : two-level step sequencer for bit-serial datapaths. The inner
//           counter walks 0..cfg_inner; the outer counter repeats that walk
//           cfg_outer+1 times. Runs one-shot (ends with a done pulse) or
//           continuous (outer wraps until stop clears the continuous flag).
// Ports   :
//   clk  in  clock, all state updates on the rising edge
//   rst  in  synchronous reset, active-high; aborts a run without done
//   bus  slave modport of bs_step_sequencer_if (controls in, steps/strobes out)
// -----------------------------------------------------------------------------
module bs_step_sequencer #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bs_step_sequencer_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IN_W-1:0]  inner_r;
    logic [IN_W-1:0]  inner_s;
    logic [IN_W-1:0]  inner_max_r;
    logic [IN_W-1:0]  inner_max_s;
    logic [OUT_W-1:0] outer_r;
    logic [OUT_W-1:0] outer_s;
    logic [OUT_W-1:0] outer_max_r;
    logic [OUT_W-1:0] outer_max_s;
    logic             cont_r;
    logic             cont_s;
    logic             done_r;
    logic             done_s;
    logic             inner_at_max_s;
    logic             outer_at_max_s;
    logic             busy_s;

    // End-of-walk detectors against the latched limits.
    assign inner_at_max_s = (inner_r == inner_max_r);
    assign outer_at_max_s = (outer_r == outer_max_r);
    assign busy_s         = (state_r == ST_RUN);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            inner_r     <= {IN_W{1'b0}};
            outer_r     <= {OUT_W{1'b0}};
            inner_max_r <= {IN_W{1'b0}};
            outer_max_r <= {OUT_W{1'b0}};
            cont_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            inner_r     <= inner_s;
            outer_r     <= outer_s;
            inner_max_r <= inner_max_s;
            outer_max_r <= outer_max_s;
            cont_r      <= cont_s;
            done_r      <= done_s;
        end
    end

    // Next-state, counter advance, config latch and done generation.
    always_comb begin
        state_s     = state_r;
        inner_s     = inner_r;
        outer_s     = outer_r;
        inner_max_s = inner_max_r;
        outer_max_s = outer_max_r;
        // stop clears the flag on the next edge; the wrap decision below
        // still uses cont_r, so a stop on the wrap step grants one more loop.
        cont_s      = bus.stop ? 1'b0 : cont_r;
        done_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s     = ST_RUN;
                    inner_s     = {IN_W{1'b0}};
                    outer_s     = {OUT_W{1'b0}};
                    inner_max_s = bus.cfg_inner;
                    outer_max_s = bus.cfg_outer;
                    // A start accepted together with stop takes cfg_cont.
                    cont_s      = bus.cfg_cont;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (!bus.en) begin
                    state_s = ST_RUN;
                end else if (!inner_at_max_s) begin
                    inner_s = inner_r + IN_W'(1);
                end else begin
                    inner_s = {IN_W{1'b0}};
                    if (!outer_at_max_s) begin
                        outer_s = outer_r + OUT_W'(1);
                    end else if (cont_r) begin
                        outer_s = {OUT_W{1'b0}};
                    end else begin
                        outer_s = {OUT_W{1'b0}};
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end
                end
            end

            default: begin
                state_s = ST_IDLE;
                inner_s = {IN_W{1'b0}};
                outer_s = {OUT_W{1'b0}};
            end
        endcase
    end

    // Strobes are decoded from registered state only.
    assign bus.busy      = busy_s;
    assign bus.inner_idx = inner_r;
    assign bus.outer_idx = outer_r;
    assign bus.first     = busy_s && (inner_r == {IN_W{1'b0}});
    assign bus.last      = busy_s && inner_at_max_s;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_bs_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bs_step_sequencer
// Self-checking bench: reset/idle checks, a table of directed vectors, hand
// sequences for stall / continuous / stop / mid-run reset, and randomized
// traffic compared against a linear-position reference model.
// -----------------------------------------------------------------------------
module tb_bs_step_sequencer;

    logic clk = 1'b0;
    logic rst;

    bs_step_sequencer_if #(.IN_W(4), .OUT_W(4)) bus ();

    bs_step_sequencer #(.IN_W(4), .OUT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int busy_cnt;
    int done_cnt;

    // Reference model: one linear position through (ci+1)*(co+1) steps.
    bit       m_busy;
    bit       m_done;
    bit       m_cont;
    int       m_pos;
    int       m_ci;
    int       m_co;

    task automatic model_step(input bit r, s, input int ci, co, input bit ct, sp, e);
        bit old_cont;
        int len;
        if (r) begin
            m_busy = 0; m_done = 0; m_cont = 0; m_pos = 0; m_ci = 0; m_co = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (s) begin
                    m_busy = 1; m_pos = 0; m_ci = ci; m_co = co; m_cont = ct;
                end else if (sp) begin
                    m_cont = 0;
                end
            end else begin
                len = (m_ci + 1) * (m_co + 1);
                old_cont = m_cont;
                if (sp) m_cont = 0;
                if (e) begin
                    if (m_pos == len - 1) begin
                        m_pos = 0;
                        if (!old_cont) begin
                            m_busy = 0;
                            m_done = 1;
                        end
                    end else begin
                        m_pos = m_pos + 1;
                    end
                end
            end
        end
    endtask

    function automatic int exp_inner();
        return m_busy ? (m_pos % (m_ci + 1)) : 0;
    endfunction

    function automatic int exp_outer();
        return m_busy ? (m_pos / (m_ci + 1)) : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic cyc(input bit r, s, input int ci, co, input bit ct, sp, e);
        rst           = r;
        bus.start     = s;
        bus.cfg_inner = 4'(ci);
        bus.cfg_outer = 4'(co);
        bus.cfg_cont  = ct;
        bus.stop      = sp;
        bus.en        = e;
        model_step(r, s, ci, co, ct, sp, e);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".busy"},  int'(bus.busy),      int'(m_busy));
        chk({tag, ".inner"}, int'(bus.inner_idx), exp_inner());
        chk({tag, ".outer"}, int'(bus.outer_idx), exp_outer());
        chk({tag, ".first"}, int'(bus.first),     int'(m_busy && exp_inner() == 0));
        chk({tag, ".last"},  int'(bus.last),      int'(m_busy && exp_inner() == m_ci));
        chk({tag, ".done"},  int'(bus.done),      int'(m_done));
    endtask

    task automatic step(input string tag, input bit s, input int ci, co, input bit ct, sp, e);
        cyc(1'b0, s, ci, co, ct, sp, e);
        cmp_model(tag);
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
    endtask

    typedef struct {
        bit start; int ci; int co; bit cont; bit stop; bit en;
        bit busy; int inner; int outer; bit first; bit last; bit done;
    } vec_t;

    function automatic vec_t mk(bit s, int ci, int co, bit ct, bit sp, bit e,
                                bit b, int in, int ou, bit f, bit l, bit d);
        vec_t v;
        v.start = s; v.ci = ci; v.co = co; v.cont = ct; v.stop = sp; v.en = e;
        v.busy = b; v.inner = in; v.outer = ou; v.first = f; v.last = l; v.done = d;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        // One-shot 3/1: 8 busy cycles, start while busy ignored.
        tbl[0]  = mk(1, 3, 1, 0, 0, 1,  1, 0, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 1,  1, 2, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 1,  1, 3, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1,  1, 2, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1,  1, 3, 1, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        // Single-step run 0/0 with a stall, then back-to-back start on done.
        tbl[10] = mk(1, 0, 0, 0, 0, 1,  1, 0, 0, 1, 1, 0);
        tbl[11] = mk(1, 1, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0);
        tbl[12] = mk(1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        tbl[13] = mk(1, 1, 0, 0, 0, 1,  1, 0, 0, 1, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);

        // Reset, then 10 idle cycles.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("idle%0d.busy", i),  int'(bus.busy), 0);
            chk($sformatf("idle%0d.done", i),  int'(bus.done), 0);
            chk($sformatf("idle%0d.first", i), int'(bus.first), 0);
            chk($sformatf("idle%0d.last", i),  int'(bus.last), 0);
            chk($sformatf("idle%0d.idx", i),   int'({bus.inner_idx, bus.outer_idx}), 0);
        end

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            cyc(0, tbl[i].start, tbl[i].ci, tbl[i].co, tbl[i].cont, tbl[i].stop, tbl[i].en);
            chk($sformatf("vec%0d.busy", i),  int'(bus.busy),      int'(tbl[i].busy));
            chk($sformatf("vec%0d.inner", i), int'(bus.inner_idx), tbl[i].inner);
            chk($sformatf("vec%0d.outer", i), int'(bus.outer_idx), tbl[i].outer);
            chk($sformatf("vec%0d.first", i), int'(bus.first),     int'(tbl[i].first));
            chk($sformatf("vec%0d.last", i),  int'(bus.last),      int'(tbl[i].last));
            chk($sformatf("vec%0d.done", i),  int'(bus.done),      int'(tbl[i].done));
        end

        // Stall: 3/1 with en=0 for 3 cycles at inner=2 -> 11 busy cycles, one done.
        busy_cnt = 0; done_cnt = 0;
        step("stall", 1, 3, 1, 0, 0, 1);
        step("stall", 0, 0, 0, 0, 0, 1);
        step("stall", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 0, 0, 0, 0, 0, 0);
            chk("stall_hold.inner", int'(bus.inner_idx), 2);
        end
        for (int i = 0; i < 40 && bus.busy; i++) step("stall", 0, 0, 0, 0, 0, 1);
        step("stall_tail", 0, 0, 0, 0, 0, 1);
        chk("stall.busy_cycles", busy_cnt, 11);
        chk("stall.done_count", done_cnt, 1);

        // Continuous 1/2, stop at step 9 -> 12 steps then done.
        busy_cnt = 0; done_cnt = 0;
        step("cont", 1, 1, 2, 1, 0, 1);
        for (int i = 0; i < 64 && bus.busy; i++) begin
            if (busy_cnt - 1 == 6) chk("cont.wrap_outer", int'(bus.outer_idx), 0);
            step("cont", 0, 0, 0, 0, (busy_cnt - 1 == 9), 1);
        end
        chk("cont.steps", busy_cnt, 12);
        chk("cont.done_count", done_cnt, 1);

        // Start with stop (cfg_cont wins), then stop on the wrap step -> one more loop.
        busy_cnt = 0; done_cnt = 0;
        step("stopwrap", 1, 1, 2, 1, 1, 1);
        for (int i = 0; i < 64 && bus.busy; i++)
            step("stopwrap", 0, 0, 0, 0, (busy_cnt - 1 == 5), 1);
        chk("stopwrap.steps", busy_cnt, 12);
        chk("stopwrap.done_count", done_cnt, 1);

        // Reset mid-run at inner=2, outer=1: immediate abort, no done.
        step("midrst", 1, 3, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) step("midrst", 0, 0, 0, 0, 0, 1);
        chk("midrst.pre_inner", int'(bus.inner_idx), 2);
        chk("midrst.pre_outer", int'(bus.outer_idx), 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("midrst.busy", int'(bus.busy), 0);
        chk("midrst.idx",  int'({bus.inner_idx, bus.outer_idx}), 0);
        chk("midrst.done", int'(bus.done), 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("midrst.done_after", int'(bus.done), 0);
        chk("midrst.busy_after", int'(bus.busy), 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0));
            cmp_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
